eth_tx_arbiter: RTL and testbench
=================================

// Module: eth_tx_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter sharing the single Ethernet Tx packer byte
//  stream between NUM_SRC user AXI-stream byte sources. Sits upstream of the Tx
//  packer user interface; grants one source per packet, never interleaves bytes
//  of different packets, and enforces a maximum packet length per grant.
// PARAMETERS
//  NUM_SRC      2     number of requesting sources (2..4)
//  MAX_PKT_LEN  1024  max bytes passed per grant; forced tlast at this count
// PORTS
//  i_axi_tx_clk      in   1          Tx clock; all logic on rising edge
//  i_axi_tx_rst_n    in   1          async assert, active-low reset
//  i_src_en          in   NUM_SRC    per-source enable mask (config)
//  i_src_tdata       in   8*NUM_SRC  source bytes; src k at [8k+7:8k]
//  i_src_tvalid      in   NUM_SRC    source byte valid
//  i_src_tlast       in   NUM_SRC    source last byte of packet
//  o_src_tready      out  NUM_SRC    source ready (only granted bit may be 1)
//  o_tx_tdata        out  8          byte to Tx packer
//  o_tx_tvalid       out  1          byte valid to Tx packer
//  o_tx_tlast        out  1          packet end (source tlast or forced)
//  i_tx_tready       in   1          Tx packer ready
//  o_grant           out  NUM_SRC    one-hot current grant, 0 when idle
//  o_busy            out  1          1 while in XFER
//  o_trunc           out  1          1-cycle pulse when a packet was truncated
// BEHAVIOUR
//  Reset: async on i_axi_tx_rst_n low; o_grant=0, o_busy=0, o_trunc=0, byte
//   counter=0, last-grant pointer=NUM_SRC-1 (so src0 has first priority), state
//   IDLE. Combinational outputs go to 0 immediately since o_grant=0.
//  Datapath: combinational pass-through of granted source, no added latency:
//   o_tx_tdata=src[g].tdata, o_tx_tvalid=busy & src[g].tvalid,
//   o_src_tready[g]=busy & i_tx_tready, all other tready bits 0.
//   Handshake = o_tx_tvalid & i_tx_tready. When not busy: tvalid=0, tdata=0.
//  FSM IDLE: req = i_src_tvalid & i_src_en. If req!=0, pick first requester
//   searching pointer+1, pointer+2, ... (mod NUM_SRC); register one-hot grant,
//   clear byte counter, go XFER next cycle. Arbitration costs 1 cycle (one idle
//   gap between packets). No request -> stay IDLE.
//  FSM XFER: byte counter (16 bit) increments on each handshake.
//   o_tx_tlast = busy & (src[g].tlast | cnt==MAX_PKT_LEN-1).
//   On handshake with o_tx_tlast=1: pointer<=g, o_grant<=0, go IDLE.
//   If end was forced (cnt==MAX_PKT_LEN-1 and source tlast=0): o_trunc pulses
//   next cycle; remaining source bytes compete as a new packet.
//  i_src_en sampled only in IDLE; clearing it mid-packet does not abort XFER.
//  Source tvalid drop mid-packet: arbiter holds grant and waits (no timeout).
//  i_tx_tready low: all outputs held, counter frozen.
//  Single requester: re-granted after each 1-cycle IDLE gap.
//  Reset mid-packet: packet abandoned; downstream sees tvalid drop without tlast.
// TESTING
//  1 src0 sends 4-byte pkt 11,22,33,44 (tlast on 44), tready=1 -> o_tx bytes
//    in 4 consecutive cycles after 1-cycle arb gap, tlast on 44, o_grant=01.
//  2 src0,src1 both pending 3-byte pkts continuously -> grants alternate
//    0,1,0,1; packets never interleaved; 1 idle cycle between each.
//  3 src1 sends 1030-byte pkt, MAX_PKT_LEN=1024 -> tlast on byte 1024,
//    o_trunc pulse, remaining 6 bytes sent as a second packet with own tlast.
//  4 tready toggles 1,0,1,0 during pkt -> no byte lost/duplicated, counter
//    frozen while tready=0, source tready mirrors i_tx_tready for grantee only.
//  5 i_src_en=10 with both valid -> only src1 granted; cleared mid-packet ->
//    packet completes, then no further grant.
//  6 reset asserted mid-packet -> o_grant=0, o_tx_tvalid=0 same cycle; after
//    release, src0 wins first simultaneous arbitration.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: packet-granular round-robin arbiter feeding one Tx byte stream
// from NUM_SRC AXI-stream byte sources, with a per-grant maximum packet length.
module eth_tx_arbiter #(
  parameter int NUM_SRC     = 2,
  parameter int MAX_PKT_LEN = 1024
) (
  input  logic                 i_axi_tx_clk,
  input  logic                 i_axi_tx_rst_n,
  input  logic [NUM_SRC-1:0]   i_src_en,
  input  logic [8*NUM_SRC-1:0] i_src_tdata,
  input  logic [NUM_SRC-1:0]   i_src_tvalid,
  input  logic [NUM_SRC-1:0]   i_src_tlast,
  output logic [NUM_SRC-1:0]   o_src_tready,
  output logic [7:0]           o_tx_tdata,
  output logic                 o_tx_tvalid,
  output logic                 o_tx_tlast,
  input  logic                 i_tx_tready,
  output logic [NUM_SRC-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_trunc
);
  localparam int PW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, XFER} state_t;
  state_t             r_state, w_next;
  logic [NUM_SRC-1:0] r_grant, w_req;
  logic [PW-1:0]      r_ptr, w_pick, w_gidx, w_j;
  logic [15:0]        r_cnt;
  logic               r_trunc, w_src_valid, w_src_last, w_force, w_hs;
  logic [7:0]         w_data;
  always_comb begin
    w_data      = '0;
    w_src_valid = 1'b0;
    w_src_last  = 1'b0;
    w_gidx      = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (r_grant[k]) begin
        w_data      = i_src_tdata[8*k +: 8];
        w_src_valid = i_src_tvalid[k];
        w_src_last  = i_src_tlast[k];
        w_gidx      = PW'(k);
      end
  end
  assign o_busy       = r_state == XFER;
  assign o_grant      = r_grant;
  assign o_trunc      = r_trunc;
  assign w_force      = r_cnt == 16'(MAX_PKT_LEN - 1);
  assign o_tx_tdata   = o_busy ? w_data : '0;
  assign o_tx_tvalid  = o_busy & w_src_valid;
  assign o_tx_tlast   = o_busy & (w_src_last | w_force);
  assign o_src_tready = (o_busy & i_tx_tready) ? r_grant : '0;
  assign w_hs         = o_tx_tvalid & i_tx_tready;
  assign w_req        = i_src_tvalid & i_src_en;
  // Scan farthest-first so the requester nearest after the pointer wins.
  always_comb begin
    w_pick = '0;
    w_j    = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      w_j = PW'((int'(r_ptr) + i) % NUM_SRC);
      if (w_req[w_j]) w_pick = w_j;
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && |w_req) w_next = XFER;
    if (r_state == XFER && w_hs && o_tx_tlast) w_next = IDLE;
  end
  always_ff @(posedge i_axi_tx_clk or negedge i_axi_tx_rst_n)
    if (!i_axi_tx_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(NUM_SRC - 1);
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trunc <= w_hs & w_force & ~w_src_last;
      if (r_state == IDLE && |w_req) begin
        r_grant <= NUM_SRC'(1) << w_pick;
        r_cnt   <= '0;
      end else if (w_hs) begin
        r_cnt <= r_cnt + 16'd1;
        if (o_tx_tlast) begin
          r_ptr   <= w_gidx;
          r_grant <= '0;
        end
      end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: scoreboard bench; expected bytes (with modelled forced tlast)
// are queued per source at stimulus time and popped on each Tx handshake.
module tb_eth_tx_arbiter;
  localparam int MAX = 1024;
  typedef struct packed {logic [7:0] d; logic l; logic t;} beat_t;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] i_src_en = 2'b11, i_src_tvalid = '0, i_src_tlast = '0, o_src_tready, o_grant;
  logic [15:0] i_src_tdata = '0;
  logic [7:0] o_tx_tdata;
  logic       o_tx_tvalid, o_tx_tlast, o_busy, o_trunc, i_tx_tready = 1'b1;
  beat_t      src0_q[$], src1_q[$], exp0_q[$], exp1_q[$];
  bit         glog[$];
  int         total = 0, bad = 0, trunc_seen = 0, n;
  bit         gap_pend = 0, tr_pend = 0, in_pkt = 0, toggle = 0, rdy_chk = 0;

  eth_tx_arbiter #(.NUM_SRC(2), .MAX_PKT_LEN(MAX)) dut (
    .i_axi_tx_clk(clk), .i_axi_tx_rst_n(rst_n), .i_src_en(i_src_en),
    .i_src_tdata(i_src_tdata), .i_src_tvalid(i_src_tvalid), .i_src_tlast(i_src_tlast),
    .o_src_tready(o_src_tready), .o_tx_tdata(o_tx_tdata), .o_tx_tvalid(o_tx_tvalid),
    .o_tx_tlast(o_tx_tlast), .i_tx_tready(i_tx_tready), .o_grant(o_grant),
    .o_busy(o_busy), .o_trunc(o_trunc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_pkt(input int src, input logic [7:0] base, input logic [7:0] stp, input int len);
    int pos = 0;
    for (int i = 0; i < len; i++) begin
      logic [7:0] d = base + 8'(i) * stp;
      bit last = (i == len - 1), f = (pos == MAX - 1);
      beat_t b = '{d, last, 1'b0}, e = '{d, last | f, f & ~last};
      if (src == 0) begin src0_q.push_back(b); exp0_q.push_back(e); end
      else begin src1_q.push_back(b); exp1_q.push_back(e); end
      pos = (last | f) ? 0 : pos + 1;
    end
  endtask

  task automatic step();
    beat_t e;
    i_src_tvalid = {src1_q.size() != 0, src0_q.size() != 0};
    i_src_tdata  = {src1_q.size() != 0 ? src1_q[0].d : 8'h0, src0_q.size() != 0 ? src0_q[0].d : 8'h0};
    i_src_tlast  = {src1_q.size() != 0 ? src1_q[0].l : 1'b0, src0_q.size() != 0 ? src0_q[0].l : 1'b0};
    if (toggle) i_tx_tready = ~i_tx_tready;
    @(negedge clk);
    if (gap_pend) chk("gap", 32'(o_busy), 0);
    gap_pend = 0;
    chk("trunc", 32'(o_trunc), 32'(tr_pend));
    tr_pend = 0;
    if (o_trunc) trunc_seen++;
    if (rdy_chk) chk("src_rdy", 32'(o_src_tready), (o_busy && i_tx_tready) ? 2'b01 : 2'b00);
    if (o_src_tready[0] & i_src_tvalid[0]) void'(src0_q.pop_front());
    if (o_src_tready[1] & i_src_tvalid[1]) void'(src1_q.pop_front());
    if (o_tx_tvalid & i_tx_tready) begin
      if (o_grant == 2'b01 && exp0_q.size() != 0) e = exp0_q.pop_front();
      else if (o_grant == 2'b10 && exp1_q.size() != 0) e = exp1_q.pop_front();
      else begin chk("unexpected_byte", 32'(o_grant), 0); e = '0; end
      chk("data", 32'(o_tx_tdata), 32'(e.d));
      chk("last", 32'(o_tx_tlast), 32'(e.l));
      if (!in_pkt) glog.push_back(o_grant[1]);
      in_pkt   = !o_tx_tlast;
      tr_pend  = e.t;
      gap_pend = o_tx_tlast;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int cnt);
    cnt = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && cnt < budget) begin
      step();
      cnt++;
    end
    chk(tag, 32'(exp0_q.size() + exp1_q.size()), 0);
    step();
    step();
  endtask

  task automatic clear_all();
    src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete(); glog.delete();
    gap_pend = 0; tr_pend = 0; in_pkt = 0;
    i_src_tvalid = '0; i_src_tlast = '0; i_src_tdata = '0;
  endtask

  initial begin
    #1;
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_tvalid", 32'(o_tx_tvalid), 0);
    chk("rst_trunc", 32'(o_trunc), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // single 4-byte packet: one arbitration cycle, then 4 back-to-back bytes
    push_pkt(0, 8'h11, 8'h11, 4);
    step();
    chk("t1_grant", 32'(o_grant), 2'b01);
    chk("t1_busy", 32'(o_busy), 1);
    drain("t1_drain", 20, n);
    chk("t1_cycles", 32'(n), 4);
    chk("t1_pkts", 32'(glog.size()), 1);
    // two continuous requesters alternate, pointer last at src0
    glog.delete();
    for (int p = 0; p < 3; p++) begin
      push_pkt(0, 8'(8'h20 + 8'(p) * 8'h10), 8'h1, 3);
      push_pkt(1, 8'(8'ha0 + 8'(p) * 8'h10), 8'h1, 3);
    end
    drain("t2_drain", 100, n);
    chk("t2_pkts", 32'(glog.size()), 6);
    for (int i = 0; i < glog.size() && i < 6; i++) chk("t2_order", 32'(glog[i]), (i % 2 == 0) ? 1 : 0);
    // oversize packet from src1 is split at MAX bytes
    glog.delete();
    trunc_seen = 0;
    push_pkt(1, 8'h00, 8'h01, MAX + 6);
    drain("t3_drain", 2 * MAX, n);
    chk("t3_pkts", 32'(glog.size()), 2);
    chk("t3_trunc_cnt", 32'(trunc_seen), 1);
    // downstream back-pressure toggling every cycle
    push_pkt(0, 8'h50, 8'h03, 5);
    toggle = 1; rdy_chk = 1;
    drain("t4_drain", 40, n);
    toggle = 0; rdy_chk = 0; i_tx_tready = 1'b1;
    // only src1 enabled; disable mid-packet, packet still completes
    i_src_en = 2'b10;
    push_pkt(0, 8'h70, 8'h01, 4);
    push_pkt(1, 8'hc0, 8'h01, 8);
    step();
    chk("t5_grant", 32'(o_grant), 2'b10);
    repeat (3) step();
    i_src_en = 2'b00;
    n = 0;
    while (exp1_q.size() != 0 && n < 30) begin step(); n++; end
    chk("t5_src1_done", 32'(exp1_q.size()), 0);
    repeat (5) step();
    chk("t5_no_regrant", 32'(o_grant), 0);
    chk("t5_src0_wait", 32'(exp0_q.size()), 4);
    // reset mid-packet, then src0 wins the first simultaneous arbitration
    clear_all();
    i_src_en = 2'b11;
    push_pkt(0, 8'h01, 8'h01, 20);
    repeat (6) step();
    chk("t6_busy_before", 32'(o_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(o_grant), 0);
    chk("t6_rst_tvalid", 32'(o_tx_tvalid), 0);
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push_pkt(0, 8'h31, 8'h01, 3);
    push_pkt(1, 8'hb1, 8'h01, 3);
    step();
    chk("t6_first_grant", 32'(o_grant), 2'b01);
    drain("t6_drain", 40, n);
    chk("t6_pkts", 32'(glog.size()), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
